// File: rtl/hps_cmd_initiator.sv
// Initiator end of the ENABLE/DONE four-phase handshake. Commands from the HPS
// write path are buffered in a small FIFO and issued one at a time under a watchdog.
module hps_cmd_initiator #(
  parameter int CMD_W          = 32,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int CNT_W          = 16,
  localparam int AW            = $clog2(FIFO_DEPTH),
  localparam int LW            = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  input  logic [CMD_W-1:0] cmd_data,
  output logic             cmd_ready,
  output logic             enable_out,
  output logic [CMD_W-1:0] cmd_out,
  input  logic             done_in,
  input  logic             err_clear,
  output logic             busy,
  output logic             timeout_err,
  output logic [CNT_W-1:0] completed_count,
  output logic [LW-1:0]    fifo_level,
  output logic [1:0]       dbg_state
);

  // Handshake: a push happens on a rising clk edge where cmd_valid && cmd_ready;
  // cmd_ready depends only on registered FIFO state, never on cmd_valid.

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    RELEASE = 2'd2,
    ERROR   = 2'd3
  } state_t;

  localparam int WD_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST =
    WD_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam logic WD_ON = (TIMEOUT_CYCLES != 0);

  // ---------------- FIFO ----------------
  logic [CMD_W-1:0] mem_q [FIFO_DEPTH];
  logic [CMD_W-1:0] mem_d [FIFO_DEPTH];
  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic [LW-1:0]    level;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic [CMD_W-1:0] fifo_head;

  assign level      = wptr_q - rptr_q;
  assign fifo_full  = (level == LW'(FIFO_DEPTH));
  assign fifo_empty = (level == '0);
  assign fifo_head  = mem_q[rptr_q[AW-1:0]];
  assign push       = cmd_valid && !fifo_full;

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push) begin
      mem_d[wptr_q[AW-1:0]] = cmd_data;
      wptr_d                = wptr_q + 1'b1;
    end
    if (pop) begin
      rptr_d = rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // ---------------- Handshake FSM ----------------
  state_t           state_q, state_d;
  logic             enable_q, enable_d;
  logic [CMD_W-1:0] cmd_out_q, cmd_out_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic             timeout_err_q, timeout_err_d;
  logic             wd_run;
  logic             wd_hit;

  assign wd_hit = WD_ON && (wd_q == WD_LAST);

  always_comb begin
    state_d   = state_q;
    enable_d  = enable_q;
    cmd_out_d = cmd_out_q;
    count_d   = count_q;
    pop       = 1'b0;
    wd_run    = 1'b0;
    case (state_q)
      IDLE: begin
        enable_d = 1'b0;
        if (done_in) begin
          // Stale DONE from the responder: hold off and let the watchdog run.
          wd_run = 1'b1;
          if (wd_hit) begin
            state_d = ERROR;
          end
        end else if (!fifo_empty) begin
          pop       = 1'b1;
          cmd_out_d = fifo_head;
          enable_d  = 1'b1;
          state_d   = ASSERT;
        end
      end
      ASSERT: begin
        wd_run = 1'b1;
        if (done_in) begin
          enable_d = 1'b0;
          count_d  = count_q + 1'b1;
          state_d  = RELEASE;
        end else if (wd_hit) begin
          enable_d = 1'b0;
          state_d  = ERROR;
        end
      end
      RELEASE: begin
        enable_d = 1'b0;
        wd_run   = 1'b1;
        if (!done_in) begin
          state_d = IDLE;
        end else if (wd_hit) begin
          state_d = ERROR;
        end
      end
      ERROR: begin
        enable_d = 1'b0;
        if (err_clear && !done_in) begin
          state_d = IDLE;
        end
      end
      default: begin
        enable_d = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  always_comb begin
    wd_d = wd_q;
    if (state_d != state_q) begin
      wd_d = '0;
    end else if (wd_run && WD_ON) begin
      wd_d = wd_q + 1'b1;
    end
    timeout_err_d = (state_d == ERROR);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      enable_q      <= 1'b0;
      cmd_out_q     <= '0;
      count_q       <= '0;
      wd_q          <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      enable_q      <= enable_d;
      cmd_out_q     <= cmd_out_d;
      count_q       <= count_d;
      wd_q          <= wd_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign cmd_ready       = !fifo_full;
  assign enable_out      = enable_q;
  assign cmd_out         = cmd_out_q;
  assign busy            = (state_q != IDLE) || !fifo_empty;
  assign timeout_err     = timeout_err_q;
  assign completed_count = count_q;
  assign fifo_level      = level;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_hps_cmd_initiator.sv
// Directed bench for hps_cmd_initiator: expected issue order kept in a queue and
// checked by a monitor on every rising enable_out; timing and flags checked inline.
module tb_hps_cmd_initiator;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic [31:0] cmd_data;
  logic        cmd_ready;
  logic        enable_out;
  logic [31:0] cmd_out;
  logic        done_in;
  logic        err_clear;
  logic        busy;
  logic        timeout_err;
  logic [3:0]  completed_count;
  logic [2:0]  fifo_level;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic        prev_en = 1'b0;
  logic [31:0] last_cmd = '0;

  hps_cmd_initiator #(
    .CMD_W(32), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(20), .CNT_W(4)
  ) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
    .cmd_ready(cmd_ready), .enable_out(enable_out), .cmd_out(cmd_out),
    .done_in(done_in), .err_clear(err_clear), .busy(busy),
    .timeout_err(timeout_err), .completed_count(completed_count),
    .fifo_level(fifo_level), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout act=running req=finished");
    $fatal(1, "bench time limit");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s act=%0h req=%0h", name, act, req);
    end
  endtask

  task automatic reset_dut();
    cmd_valid = 1'b0;
    cmd_data  = '0;
    done_in   = 1'b0;
    err_clear = 1'b0;
    reset     = 1'b1;
    exp_q.delete();
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic push(input logic [31:0] d);
    chk("push_ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_data  = d;
    exp_q.push_back(d);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_en(input logic lvl, input int budget);
    int n = 0;
    while (enable_out !== lvl && n < budget) begin
      tick();
      n++;
    end
    chk("wait_enable", 32'(enable_out), 32'(lvl));
  endtask

  task automatic serve(input int lat);
    wait_en(1'b1, 40);
    repeat (lat) tick();
    done_in = 1'b1;
    tick();
    chk("en_fall", 32'(enable_out), 32'd0);
    done_in = 1'b0;
    tick();
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (reset) begin
      prev_en = 1'b0;
    end else begin
      if (enable_out && !prev_en) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL issue_unexpected act=%0h req=none", cmd_out);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          if (cmd_out !== e) begin
            errors++;
            $display("FAIL issue_order act=%0h req=%0h", cmd_out, e);
          end
        end
        last_cmd = cmd_out;
      end else if (enable_out && prev_en) begin
        checks++;
        if (cmd_out !== last_cmd) begin
          errors++;
          $display("FAIL cmd_stable act=%0h req=%0h", cmd_out, last_cmd);
        end
      end
      prev_en = enable_out;
    end
  end

  // ---------------- directed tests ----------------
  logic [2:0] lvl_tab [6] = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4};
  logic       rdy_tab [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    int n;
    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_data = '0;
    done_in = 1'b0;
    err_clear = 1'b0;
    tick();
    chk("rst_enable", 32'(enable_out), 32'd0);
    chk("rst_cmd_out", cmd_out, 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(timeout_err), 32'd0);
    chk("rst_count", 32'(completed_count), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);

    // Single command: enable two edges after the push is driven, done after 10 cycles.
    reset_dut();
    push(32'hA5A5_0001);
    chk("t1_no_early_enable", 32'(enable_out), 32'd0);
    tick();
    chk("t1_enable_rise", 32'(enable_out), 32'd1);
    chk("t1_cmd_out", cmd_out, 32'hA5A5_0001);
    repeat (10) tick();
    chk("t1_enable_hold", 32'(enable_out), 32'd1);
    done_in = 1'b1;
    tick();
    chk("t1_enable_fall", 32'(enable_out), 32'd0);
    chk("t1_count", 32'(completed_count), 32'd1);
    chk("t1_busy_release", 32'(busy), 32'd1);
    done_in = 1'b0;
    tick();
    chk("t1_busy_drop", 32'(busy), 32'd0);
    chk("t1_cmd_out_kept", cmd_out, 32'hA5A5_0001);

    // Burst into a stalled responder; second attempt lands on the issue pop.
    reset_dut();
    for (int i = 0; i < 6; i++) begin
      cmd_valid = 1'b1;
      cmd_data  = 32'hB000_0000 + 32'(i);
      chk("t2_ready", 32'(cmd_ready), 32'(rdy_tab[i]));
      chk("t2_level", 32'(fifo_level), 32'(lvl_tab[i]));
      if (rdy_tab[i]) exp_q.push_back(cmd_data);
      tick();
    end
    cmd_valid = 1'b0;
    chk("t2_level_full", 32'(fifo_level), 32'd4);
    for (int i = 0; i < 5; i++) serve(2);
    chk("t2_count", 32'(completed_count), 32'd5);
    chk("t2_level_end", 32'(fifo_level), 32'd0);
    chk("t2_busy_end", 32'(busy), 32'd0);

    // Watchdog in ASSERT: 20 enable cycles then ERROR; queued command survives.
    reset_dut();
    push(32'hC000_0001);
    push(32'hC000_0002);
    wait_en(1'b1, 5);
    n = 0;
    while (enable_out && n < 40) begin
      tick();
      n++;
    end
    chk("t3_assert_cycles", 32'(n), 32'd20);
    chk("t3_err", 32'(timeout_err), 32'd1);
    chk("t3_count", 32'(completed_count), 32'd0);
    chk("t3_level", 32'(fifo_level), 32'd1);
    repeat (3) tick();
    chk("t3_no_issue", 32'(enable_out), 32'd0);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    chk("t3_err_cleared", 32'(timeout_err), 32'd0);
    tick();
    chk("t3_next_issue", 32'(enable_out), 32'd1);
    serve(1);
    chk("t3_count_after", 32'(completed_count), 32'd1);

    // DONE stuck high in RELEASE.
    reset_dut();
    push(32'hD000_0001);
    push(32'hD000_0002);
    wait_en(1'b1, 5);
    repeat (2) tick();
    done_in = 1'b1;
    tick();
    chk("t4_release", 32'(enable_out), 32'd0);
    n = 0;
    while (!timeout_err && n < 40) begin
      tick();
      n++;
    end
    chk("t4_release_cycles", 32'(n), 32'd20);
    chk("t4_count", 32'(completed_count), 32'd1);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    chk("t4_clear_ignored", 32'(timeout_err), 32'd1);
    chk("t4_state_err", 32'(dbg_state), 32'd3);
    done_in = 1'b0;
    repeat (3) tick();
    chk("t4_still_err", 32'(timeout_err), 32'd1);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    chk("t4_err_cleared", 32'(timeout_err), 32'd0);
    tick();
    chk("t4_next_issue", 32'(enable_out), 32'd1);
    serve(1);
    chk("t4_count_after", 32'(completed_count), 32'd2);

    // Asynchronous reset in the middle of ASSERT with three commands queued.
    reset_dut();
    push(32'hE000_0000);
    serve(1);
    for (int i = 1; i < 5; i++) push(32'hE000_0000 + 32'(i));
    chk("t5_pre_level", 32'(fifo_level), 32'd3);
    chk("t5_pre_enable", 32'(enable_out), 32'd1);
    #2;
    reset = 1'b1;
    exp_q.delete();
    #1;
    chk("t5_async_enable", 32'(enable_out), 32'd0);
    chk("t5_level", 32'(fifo_level), 32'd0);
    chk("t5_count", 32'(completed_count), 32'd0);
    tick();
    reset = 1'b0;
    repeat (10) tick();
    chk("t5_no_issue", 32'(enable_out), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    push(32'hE000_0005);
    serve(1);
    chk("t5_count_after", 32'(completed_count), 32'd1);

    // completed_count wraps with a 4-bit counter.
    reset_dut();
    for (int i = 0; i < 17; i++) begin
      push(32'hF000_0000 + 32'(i));
      serve(0);
      if (i == 15) chk("t6_wrap_zero", 32'(completed_count), 32'd0);
    end
    chk("t6_wrap_one", 32'(completed_count), 32'd1);

    repeat (3) tick();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
